// File: rtl/iic_cmd_sched_if.sv
// iic_cmd_sched_if: requester handshake plus iic_top register-port bundle for the command scheduler
interface iic_cmd_sched_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] req_valid;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic [1:0] rsp_status;
  logic busy;
  logic [1:0] m_adr;
  logic [7:0] m_wdata;
  logic m_cs;
  logic m_next;
  logic [7:0] m_rdata;
  modport slave (
    input req_valid, req_addr, req_data, m_rdata,
    output req_ready, rsp_valid, rsp_status, busy, m_adr, m_wdata, m_cs, m_next
  );
  modport master (
    output req_valid, req_addr, req_data, m_rdata,
    input req_ready, rsp_valid, rsp_status, busy, m_adr, m_wdata, m_cs, m_next
  );
endinterface

// File: rtl/iic_cmd_sched.sv
// iic_cmd_sched: round-robin scheduler running single-byte I2C writes through the iic_top register port
module iic_cmd_sched #(
  parameter int NREQ = 2,
  parameter int TO_CYC = 4095
) (
  input logic clk,
  input logic rst,
  iic_cmd_sched_if.slave bus
);
  typedef enum logic [3:0] {IDLE, LD_ADR, LD_CTR, WT_ACK1, LD_DAT, NXT, WT_ACK2, STOP, WT_AVL, RSP} state_t;
  localparam logic [11:0] TO_LAST = 12'(TO_CYC - 1);
  localparam logic [2:0] N3 = 3'(NREQ);
  state_t state, nxt;
  logic [1:0] last, nlast, gnt, st, nst;
  logic [6:0] addr, naddr, ga;
  logic [7:0] data, ndata, gd;
  logic [11:0] cnt;
  logic [3:0] v4;
  logic [2:0] s;
  logic seen, hit, wt, rd_ok, tmo;
  assign v4 = 4'(bus.req_valid);
  assign wt = state == WT_ACK1 || state == WT_ACK2 || state == WT_AVL;
  assign rd_ok = cnt != 12'd0;
  assign tmo = cnt == TO_LAST;
  always_comb begin
    hit = 1'b0;
    gnt = last;
    s = '0;
    for (int k = NREQ; k >= 1; k--) begin
      s = {1'b0, last} + 3'(k);
      s = s >= N3 ? s - N3 : s;
      if (v4[s[1:0]]) begin
        hit = 1'b1;
        gnt = s[1:0];
      end
    end
  end
  always_comb begin
    ga = '0;
    gd = '0;
    for (int k = 0; k < NREQ; k++)
      if (gnt == 2'(k)) begin
        ga = bus.req_addr[7*k +: 7];
        gd = bus.req_data[8*k +: 8];
      end
  end
  always_comb begin
    nxt = state;
    nst = st;
    nlast = last;
    naddr = addr;
    ndata = data;
    case (state)
      IDLE: if (hit) begin
        nxt = LD_ADR;
        nst = 2'b00;
        nlast = gnt;
        naddr = ga;
        ndata = gd;
      end
      LD_ADR: nxt = LD_CTR;
      LD_CTR: nxt = WT_ACK1;
      WT_ACK1:
        if (rd_ok && bus.m_rdata == 8'h08) nxt = LD_DAT;
        else if (rd_ok && bus.m_rdata == 8'h0C) begin
          nxt = STOP;
          nst = 2'b01;
        end else if (tmo) begin
          nxt = STOP;
          nst = 2'b10;
        end
      LD_DAT: nxt = NXT;
      NXT: nxt = WT_ACK2;
      WT_ACK2:
        if (rd_ok && bus.m_rdata == 8'h0C) begin
          nxt = STOP;
          nst = 2'b01;
        end else if (rd_ok && seen && bus.m_rdata == 8'h08) nxt = STOP;
        else if (tmo) begin
          nxt = STOP;
          nst = 2'b10;
        end
      STOP: nxt = WT_AVL;
      WT_AVL:
        if (rd_ok && bus.m_rdata == 8'h00) nxt = RSP;
        else if (tmo) begin
          nxt = RSP;
          nst = st == 2'b01 ? 2'b01 : 2'b10;
        end
      RSP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 2'(NREQ - 1);
      addr <= '0;
      data <= '0;
      st <= 2'b00;
      cnt <= '0;
      seen <= 1'b0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_status <= 2'b00;
      bus.busy <= 1'b0;
      bus.m_adr <= 2'b10;
      bus.m_wdata <= 8'h00;
      bus.m_cs <= 1'b0;
      bus.m_next <= 1'b0;
    end else begin
      state <= nxt;
      last <= nlast;
      addr <= naddr;
      data <= ndata;
      st <= nst;
      cnt <= (nxt == state && wt) ? cnt + 12'd1 : '0;
      seen <= nxt == state && (seen || (rd_ok && bus.m_rdata != 8'h08));
      bus.req_ready <= (state == IDLE && hit) ? NREQ'(1) << gnt : '0;
      bus.rsp_valid <= nxt == RSP ? NREQ'(1) << last : '0;
      bus.rsp_status <= nxt == RSP ? nst : 2'b00;
      bus.busy <= nxt != IDLE;
      bus.m_cs <= nxt != IDLE;
      bus.m_next <= nxt == NXT;
      bus.m_adr <= (nxt == LD_ADR || nxt == LD_DAT) ? 2'b00 : (nxt == LD_CTR || nxt == STOP) ? 2'b11 : 2'b10;
      bus.m_wdata <= nxt == LD_ADR ? {naddr, 1'b0} : nxt == LD_CTR ? 8'h03 : nxt == LD_DAT ? ndata :
                     nxt == STOP ? 8'h01 : 8'h00;
    end
  end
endmodule

// File: tb/tb_iic_cmd_sched.sv
// tb_iic_cmd_sched: directed checks of the scheduler against a small iic_top status-register model
module tb_iic_cmd_sched;
  localparam int NREQ = 2;
  localparam logic [2:0] P_NONE = 3'd0, P_START = 3'd1, P_ADR = 3'd2, P_NXT = 3'd3, P_DATA = 3'd4, P_END = 3'd5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  iic_cmd_sched_if #(.NREQ(NREQ)) bus();
  iic_cmd_sched #(.NREQ(NREQ), .TO_CYC(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int n_cmp = 0, n_err = 0, cyc = 0, nxt_n = 0, tmr = 0;
  logic [7:0] txr_q[$], ctr_q[$];
  int ctr_cyc[$], gnt_cyc[$], rsp_cyc[$];
  logic [NREQ-1:0] gnt_q[$];
  logic [3:0] rsp_q[$];
  logic [7:0] sr, sr_rsp;
  logic [2:0] ph;
  logic dack, dack_rsp, busy_rsp, nack_mode, hang_mode, stuck_end;
  always @(posedge clk) begin
    if (rst) begin
      sr <= 8'h00;
      ph <= P_NONE;
      tmr <= 0;
      dack <= 1'b0;
      bus.m_rdata <= 8'h00;
    end else begin
      bus.m_rdata <= bus.m_adr == 2'b10 ? sr : 8'h00;
      if (bus.m_cs && bus.m_adr == 2'b11 && bus.m_wdata == 8'h03) begin
        sr <= 8'h09;
        ph <= hang_mode ? P_NONE : P_START;
        tmr <= 3;
      end else if (bus.m_cs && bus.m_adr == 2'b11 && bus.m_wdata == 8'h01) begin
        if (!hang_mode) sr <= 8'h0C;
        ph <= (hang_mode || stuck_end) ? P_NONE : P_END;
        tmr <= 3;
      end else if (bus.m_next) begin
        ph <= P_NXT;
        tmr <= 2;
      end else if (tmr > 0) tmr <= tmr - 1;
      else
        case (ph)
          P_START: begin sr <= 8'h0A; ph <= P_ADR; tmr <= 3; end
          P_ADR: begin sr <= nack_mode ? 8'h0C : 8'h08; ph <= P_NONE; end
          P_NXT: begin sr <= 8'h0A; ph <= P_DATA; tmr <= 3; end
          P_DATA: begin sr <= 8'h08; dack <= 1'b1; ph <= P_NONE; end
          P_END: begin sr <= 8'h00; ph <= P_NONE; end
          default: ;
        endcase
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (bus.m_cs && bus.m_adr == 2'b00) txr_q.push_back(bus.m_wdata);
    if (bus.m_cs && bus.m_adr == 2'b11) begin
      ctr_q.push_back(bus.m_wdata);
      ctr_cyc.push_back(cyc);
    end
    if (bus.m_next) nxt_n++;
    if (|bus.req_ready) begin
      gnt_q.push_back(bus.req_ready);
      gnt_cyc.push_back(cyc);
    end
    if (|bus.rsp_valid) begin
      rsp_q.push_back({bus.rsp_valid, bus.rsp_status});
      rsp_cyc.push_back(cyc);
      sr_rsp = sr;
      dack_rsp = dack;
      busy_rsp = bus.busy;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic nk, input logic hg, input logic se);
    rst = 1'b1;
    bus.req_valid = '0;
    nack_mode = nk;
    hang_mode = hg;
    stuck_end = se;
    tick;
    tick;
    rst = 1'b0;
    txr_q.delete();
    ctr_q.delete();
    ctr_cyc.delete();
    gnt_q.delete();
    gnt_cyc.delete();
    rsp_q.delete();
    rsp_cyc.delete();
    nxt_n = 0;
  endtask
  task automatic wait_rsp(input int n, input logic drop);
    int k = 0;
    while (rsp_q.size() < n && k < 400) begin
      tick;
      if (drop) bus.req_valid &= ~bus.req_ready;
      k++;
    end
    chk("rsp_arrived", 32'(rsp_q.size() >= n), 1);
  endtask
  initial begin
    int k;
    bus.req_valid = '0;
    bus.req_addr = {7'h21, 7'h50};
    bus.req_data = {8'h3C, 8'hA5};
    do_reset(1'b0, 1'b0, 1'b0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_status", bus.rsp_status, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_m_adr", bus.m_adr, 2);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_m_cs", bus.m_cs, 0);
    chk("rst_m_next", bus.m_next, 0);
    bus.req_valid = 2'b01;
    wait_rsp(1, 1'b1);
    chk("a_gnt_n", gnt_q.size(), 1);
    chk("a_gnt", gnt_q[0], 1);
    chk("a_txr_n", txr_q.size(), 2);
    chk("a_txr_adr", txr_q[0], 8'hA0);
    chk("a_txr_dat", txr_q[1], 8'hA5);
    chk("a_ctr_n", ctr_q.size(), 2);
    chk("a_ctr_start", ctr_q[0], 8'h03);
    chk("a_ctr_stop", ctr_q[1], 8'h01);
    chk("a_next_n", nxt_n, 1);
    chk("a_rsp", rsp_q[0], 4'b0100);
    chk("a_sr_at_rsp", sr_rsp, 8'h00);
    chk("a_data_acked", dack_rsp, 1);
    chk("a_busy_at_rsp", busy_rsp, 1);
    chk("a_busy_after", bus.busy, 0);
    chk("a_cs_after", bus.m_cs, 0);
    do_reset(1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b11;
    wait_rsp(4, 1'b0);
    bus.req_valid = '0;
    for (k = 0; k < 4; k++) begin
      chk("b_gnt", gnt_q[k], 1 << (k % 2));
      chk("b_rsp", rsp_q[k], (1 << (k % 2)) << 2);
      chk("b_txr_adr", txr_q[2*k], (k % 2) ? 8'h42 : 8'hA0);
      chk("b_txr_dat", txr_q[2*k+1], (k % 2) ? 8'h3C : 8'hA5);
    end
    chk("b_idle_gap", gnt_cyc[1] - rsp_cyc[0], 2);
    do_reset(1'b1, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    wait_rsp(1, 1'b1);
    chk("c_txr_n", txr_q.size(), 1);
    chk("c_txr_adr", txr_q[0], 8'hA0);
    chk("c_ctr_n", ctr_q.size(), 2);
    chk("c_ctr_stop", ctr_q[1], 8'h01);
    chk("c_next_n", nxt_n, 0);
    chk("c_rsp", rsp_q[0], 4'b0101);
    chk("c_sr_at_rsp", sr_rsp, 8'h00);
    do_reset(1'b0, 1'b1, 1'b0);
    bus.req_valid = 2'b01;
    wait_rsp(1, 1'b1);
    chk("d_ctr_n", ctr_q.size(), 2);
    chk("d_ctr_stop", ctr_q[1], 8'h01);
    chk("d_ack_wait", ctr_cyc[1] - ctr_cyc[0], 17);
    chk("d_avl_wait", rsp_cyc[0] - ctr_cyc[1], 17);
    chk("d_rsp", rsp_q[0], 4'b0110);
    chk("d_next_n", nxt_n, 0);
    chk("d_txr_n", txr_q.size(), 1);
    do_reset(1'b1, 1'b0, 1'b1);
    bus.req_valid = 2'b01;
    wait_rsp(1, 1'b1);
    chk("e_rsp", rsp_q[0], 4'b0101);
    chk("e_avl_wait", rsp_cyc[0] - ctr_cyc[1], 17);
    do_reset(1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    k = 0;
    while (!bus.m_next && k < 200) begin
      tick;
      bus.req_valid &= ~bus.req_ready;
      k++;
    end
    chk("f_next_seen", bus.m_next, 1);
    tick;
    chk("f_wt2_adr", bus.m_adr, 2);
    chk("f_wt2_busy", bus.busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("f_rst_cs", bus.m_cs, 0);
    chk("f_rst_busy", bus.busy, 0);
    chk("f_rst_rsp", bus.rsp_valid, 0);
    repeat (40) tick;
    chk("f_no_rsp", rsp_q.size(), 0);
    bus.req_valid = 2'b11;
    wait_rsp(1, 1'b1);
    bus.req_valid = '0;
    chk("f_regrant", gnt_q[1], 1);
    chk("f_rsp", rsp_q[0], 4'b0100);
    do_reset(1'b0, 1'b0, 1'b0);
    bus.req_valid = 2'b01;
    tick;
    chk("g_ready", bus.req_ready, 1);
    bus.req_valid = '0;
    repeat (3) tick;
    bus.req_valid = 2'b10;
    tick;
    bus.req_valid = '0;
    wait_rsp(1, 1'b1);
    repeat (20) tick;
    chk("g_gnt_n", gnt_q.size(), 1);
    chk("g_rsp", rsp_q[0], 4'b0100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
